// File: rtl/register_file_pkg.sv
// Shared RV32I core constants used by the ALU, the decoder and the register file.
package register_file_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Number of combinational read ports: RD1, RD2 and the debug port.
  localparam int unsigned NUM_RD_PORTS = 3;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file: x1..x31 in flops, x0 hard-wired to zero, one write port,
// three combinational read ports with optional same-cycle write bypass.
module register_file #(
  parameter int unsigned XLEN   = register_file_pkg::XLEN,
  parameter int unsigned BYPASS = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [register_file_pkg::REG_ADDR_W-1:0] A1,
  input  logic [register_file_pkg::REG_ADDR_W-1:0] A2,
  input  logic [register_file_pkg::REG_ADDR_W-1:0] A3,
  input  logic [XLEN-1:0]                       WD3,
  input  logic                                  WE3,
  output logic [XLEN-1:0]                       RD1,
  output logic [XLEN-1:0]                       RD2,
  input  logic [register_file_pkg::REG_ADDR_W-1:0] DbgA,
  output logic [XLEN-1:0]                       DbgRD
);

  import register_file_pkg::*;

  logic [XLEN-1:0]       regs_q [1:NUM_REGS-1];
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] raddr [NUM_RD_PORTS];
  logic [XLEN-1:0]       rdata [NUM_RD_PORTS];

  // Writes to x0 are dropped here so x0 never needs storage.
  assign wr_en = WE3 && (A3 != REG_ZERO);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (A3 == REG_ADDR_W'(i)) begin
          regs_q[i] <= WD3;
        end
      end
    end
  end

  assign raddr[0] = A1;
  assign raddr[1] = A2;
  assign raddr[2] = DbgA;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
    logic [XLEN-1:0] rd_val;

    always_comb begin
      rd_val = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (raddr[p] == REG_ADDR_W'(i)) begin
          rd_val = regs_q[i];
        end
      end
      if ((BYPASS != 0) && wr_en && (A3 == raddr[p])) begin
        rd_val = WD3;
      end
      // Reset gating overrides both the array read and the bypass.
      if (!rst) begin
        rd_val = '0;
      end
    end

    assign rdata[p] = rd_val;
  end

  assign RD1   = rdata[0];
  assign RD2   = rdata[1];
  assign DbgRD = rdata[2];

endmodule
